alu_cdb_writeback: RTL and testbench
====================================

// Module: alu_cdb_writeback
// PURPOSE
//  Integer execute + writeback stage directly downstream of reservation_station.
//  Takes up to ISSUE_W issued ops per cycle, computes 64-bit ALU results, and drives
//  them onto the CDB_W-lane common data bus. The CDB lanes feed RS wakeup and the ROB.
//  Results that cannot be broadcast in a cycle are held in an age-ordered result queue.
//  The stage raises backpressure (exec_ready) to the RS.
// PARAMETERS
//  ISSUE_W   2   issue lanes from the RS
//  CDB_W     2   CDB broadcast lanes
//  PHYS_W    6   physical register tag width
//  ROB_W     6   ROB tag width
//  RQ_DEPTH  4   result queue entries; must be >= ISSUE_W
// PORTS
//  clk             in   1                clock, rising edge
//  reset           in   1                asynchronous, active-high
//  issue_valid     in   ISSUE_W          op valid per lane
//  issue_op        in   ISSUE_W x 8      opcode
//  issue_dst_tag   in   ISSUE_W x PHYS_W destination physical tag
//  issue_src1_val  in   ISSUE_W x 64     operand 1
//  issue_src2_val  in   ISSUE_W x 64     operand 2
//  issue_rob_tag   in   ISSUE_W x ROB_W  ROB index
//  cdb_block       in   1                another unit (LSU) owns all CDB lanes next cycle
//  exec_ready      out  1                RS may issue this cycle
//  cdb_valid       out  CDB_W            broadcast valid (registered)
//  cdb_tag         out  CDB_W x PHYS_W   broadcast tag
//  cdb_value       out  CDB_W x 64       broadcast value
//  cdb_rob_tag     out  CDB_W x ROB_W    ROB index for completion
//  rq_count        out  clog2(RQ_DEPTH+1) queued result count
//  overflow_err    out  1                sticky: result dropped
// BEHAVIOUR
//  - Reset (async): cdb_valid=0; cdb_tag/value/rob_tag=0; queue empty; rq_count=0;
//    overflow_err=0; exec_ready=1. Reset mid-operation discards all queued/in-flight results.
//  - ALU (combinational on issue inputs), 64-bit wrap, no flags:
//    01 ADD a+b | 02 SUB a-b | 03 AND | 04 OR | 05 XOR | 06 LSL a<<b[5:0] | 07 LSR a>>b[5:0]
//    Any other opcode: pass-through of a.
//  - Candidate order each cycle: queue entries oldest-first, then this cycle's valid issue
//    lanes in lane order (0 before 1). Invalid lanes are skipped (no holes).
//  - If cdb_block=0: the first CDB_W candidates are registered onto cdb lanes 0..CDB_W-1.
//    Unused lanes get cdb_valid=0.
//  - If cdb_block=1: cdb_valid=0 next cycle. All candidates are kept.
//  - Remaining candidates are pushed into the queue in order; the queue is circular with
//    wrap-around head/tail. Dequeue and enqueue occur in the same edge.
//  - Latency: issue in cycle N -> cdb_valid in N+1 when queue empty and not blocked.
//    Later results never overtake older queued results.
//  - exec_ready = (RQ_DEPTH - rq_count) >= ISSUE_W, combinational from registered count.
//    It guarantees a full-width issue always fits even under cdb_block.
//  - issue_valid while exec_ready=0: accepted if space remains.
//    Otherwise the excess lanes (highest lane first) are dropped and overflow_err sets,
//    held until reset.
//  - rq_count is never > RQ_DEPTH.
//  - CDB outputs are held only one cycle. No handshake from consumers.
// TESTING
//  1) Reset, then ADD p10=5+3 rob0 on lane0 -> next cycle cdb_valid=01, tag=10, value=8,
//     rob=0; rq_count=0.
//  2) Lane0 SUB 5-7, lane1 LSL 1<<63 same cycle -> lane0 value=0xFFFF_FFFF_FFFF_FFFE,
//     lane1 value=0x8000_0000_0000_0000.
//  3) Hold cdb_block=1 for 2 cycles, issuing 2 ops each cycle -> rq_count 2 then 4;
//     exec_ready=0 at 4. Release -> oldest two broadcast first, then the next two,
//     in issue order.
//  4) Queue full, issue 2 ops with cdb_block=1 -> both dropped, overflow_err=1 stays
//     high; queued results unaffected.
//  5) Fill queue across head wrap (issue/block pattern >2 RQ_DEPTH cycles) -> every tag
//     broadcast exactly once, in order.
//  6) Assert reset while rq_count=3 -> cdb_valid=0 immediately; rq_count=0; no stale
//     result after reset release.

Source files
------------

// File: rtl/alu_cdb_writeback.sv
// Integer execute + CDB writeback stage: per-lane 64-bit ALU, age-ordered result
// queue and CDB_W-lane registered broadcast with backpressure toward the RS.
module alu_cdb_writeback #(
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned CDB_W    = 2,
   parameter int unsigned PHYS_W   = 6,
   parameter int unsigned ROB_W    = 6,
   parameter int unsigned RQ_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [ISSUE_W-1:0]                 issue_valid,
   input  logic [ISSUE_W-1:0][7:0]            issue_op,
   input  logic [ISSUE_W-1:0][PHYS_W-1:0]     issue_dst_tag,
   input  logic [ISSUE_W-1:0][63:0]           issue_src1_val,
   input  logic [ISSUE_W-1:0][63:0]           issue_src2_val,
   input  logic [ISSUE_W-1:0][ROB_W-1:0]      issue_rob_tag,
   input  logic                               cdb_block,
   output logic                               exec_ready,
   output logic [CDB_W-1:0]                   cdb_valid,
   output logic [CDB_W-1:0][PHYS_W-1:0]       cdb_tag,
   output logic [CDB_W-1:0][63:0]             cdb_value,
   output logic [CDB_W-1:0][ROB_W-1:0]        cdb_rob_tag,
   output logic [$clog2(RQ_DEPTH+1)-1:0]      rq_count,
   output logic                               overflow_err
);

   localparam int unsigned CNT_W = $clog2(RQ_DEPTH + 1);
   localparam int unsigned PTR_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
   localparam int unsigned NCAND = RQ_DEPTH + ISSUE_W;

   typedef struct packed {
      logic [PHYS_W-1:0] tag;
      logic [63:0]       value;
      logic [ROB_W-1:0]  rob;
   } result_t;

   function automatic logic [63:0] alu(input logic [7:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
      case (op)
         8'h01:   return a + b;
         8'h02:   return a - b;
         8'h03:   return a & b;
         8'h04:   return a | b;
         8'h05:   return a ^ b;
         8'h06:   return a << b[5:0];
         8'h07:   return a >> b[5:0];
         default: return a;
      endcase
   endfunction

   function automatic int unsigned wrap(input int unsigned p, input int unsigned o);
      return (p + o) % RQ_DEPTH;
   endfunction

   result_t            mem [RQ_DEPTH];
   logic [PTR_W-1:0]   head_q, tail_q;
   logic [CNT_W-1:0]   count_q;

   result_t            alu_res [ISSUE_W];
   result_t            cand [NCAND];
   int unsigned        cnt, cap, n_acc, n_cand, n_bcast, n_deq, push_base, n_push;
   logic               drop;

   logic [CDB_W-1:0]              bc_valid;
   logic [CDB_W-1:0][PHYS_W-1:0]  bc_tag;
   logic [CDB_W-1:0][63:0]        bc_value;
   logic [CDB_W-1:0][ROB_W-1:0]   bc_rob;

   logic [ISSUE_W-1:0]            push_en;
   logic [PTR_W-1:0]              push_idx  [ISSUE_W];
   result_t                       push_data [ISSUE_W];

   always_comb begin
      for (int unsigned l = 0; l < ISSUE_W; l++) begin
         alu_res[l].tag   = issue_dst_tag[l];
         alu_res[l].value = alu(issue_op[l], issue_src1_val[l], issue_src2_val[l]);
         alu_res[l].rob   = issue_rob_tag[l];
      end
   end

   // Candidates: queued entries oldest-first, then accepted issue lanes packed behind
   // them. Acceptance capacity counts the lanes that will drain this edge, so only
   // lanes that could not fit anywhere are dropped (highest lane first).
   always_comb begin
      cnt  = 32'(count_q);
      cap  = RQ_DEPTH + (cdb_block ? 0 : CDB_W) - cnt;
      for (int unsigned i = 0; i < NCAND; i++) cand[i] = '0;
      for (int unsigned i = 0; i < RQ_DEPTH; i++) cand[i] = mem[PTR_W'(wrap(32'(head_q), i))];
      n_acc = 0;
      drop  = 1'b0;
      for (int unsigned l = 0; l < ISSUE_W; l++) begin
         if (issue_valid[l]) begin
            if (n_acc < cap) begin
               cand[cnt + n_acc] = alu_res[l];
               n_acc = n_acc + 1;
            end else begin
               drop = 1'b1;
            end
         end
      end
      n_cand    = cnt + n_acc;
      n_bcast   = cdb_block ? 0 : ((n_cand < CDB_W) ? n_cand : CDB_W);
      n_deq     = (n_bcast < cnt) ? n_bcast : cnt;
      push_base = (n_bcast > cnt) ? n_bcast : cnt;
      n_push    = n_cand - push_base;
   end

   always_comb begin
      bc_valid = '0;
      bc_tag   = '0;
      bc_value = '0;
      bc_rob   = '0;
      for (int unsigned j = 0; j < CDB_W; j++) begin
         if (j < n_bcast) begin
            bc_valid[j] = 1'b1;
            bc_tag[j]   = cand[j].tag;
            bc_value[j] = cand[j].value;
            bc_rob[j]   = cand[j].rob;
         end
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         push_en[k]   = 1'b0;
         push_idx[k]  = PTR_W'(wrap(32'(tail_q), k));
         push_data[k] = '0;
         if (k < n_push) begin
            push_en[k]   = 1'b1;
            push_data[k] = cand[push_base + k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         cdb_valid    <= '0;
         cdb_tag      <= '0;
         cdb_value    <= '0;
         cdb_rob_tag  <= '0;
         overflow_err <= 1'b0;
      end else begin
         head_q       <= PTR_W'(wrap(32'(head_q), n_deq));
         tail_q       <= PTR_W'(wrap(32'(tail_q), n_push));
         count_q      <= CNT_W'(n_cand - n_bcast);
         cdb_valid    <= bc_valid;
         cdb_tag      <= bc_tag;
         cdb_value    <= bc_value;
         cdb_rob_tag  <= bc_rob;
         overflow_err <= overflow_err | drop;
      end
   end

   // Storage needs no reset: entries are only read while counted as occupied.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         if (push_en[k]) mem[push_idx[k]] <= push_data[k];
      end
   end

   assign rq_count   = count_q;
   assign exec_ready = ((RQ_DEPTH - 32'(count_q)) >= ISSUE_W);

   a_count_bound: assert property (@(posedge clk) disable iff (reset) 32'(count_q) <= RQ_DEPTH);

endmodule

// File: tb/tb_alu_cdb_writeback.sv
// Directed bench for alu_cdb_writeback: ALU vector table plus queue/block/overflow/
// reset sequences with hand-derived expectations and a small ordering scoreboard.
module tb_alu_cdb_writeback;

   logic             clk;
   logic             reset;
   logic [1:0]       issue_valid;
   logic [1:0][7:0]  issue_op;
   logic [1:0][5:0]  issue_dst_tag;
   logic [1:0][63:0] issue_src1_val;
   logic [1:0][63:0] issue_src2_val;
   logic [1:0][5:0]  issue_rob_tag;
   logic             cdb_block;
   logic             exec_ready;
   logic [1:0]       cdb_valid;
   logic [1:0][5:0]  cdb_tag;
   logic [1:0][63:0] cdb_value;
   logic [1:0][5:0]  cdb_rob_tag;
   logic [2:0]       rq_count;
   logic             overflow_err;

   int errors = 0;
   int checks = 0;

   alu_cdb_writeback #(
      .ISSUE_W(2), .CDB_W(2), .PHYS_W(6), .ROB_W(6), .RQ_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
      .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
      .issue_rob_tag(issue_rob_tag), .cdb_block(cdb_block), .exec_ready(exec_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_rob_tag(cdb_rob_tag), .rq_count(rq_count), .overflow_err(overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  v;
      logic [7:0]  op0, op1;
      logic [63:0] a0, b0, a1, b1;
      logic [5:0]  t0, t1, r0, r1;
      logic [1:0]  ev;
      logic [5:0]  et0, et1;
      logic [63:0] ex0, ex1;
      logic [5:0]  er0, er1;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int l, input logic [7:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [5:0] t, input logic [5:0] r);
      issue_op[l]       = op;
      issue_src1_val[l] = a;
      issue_src2_val[l] = b;
      issue_dst_tag[l]  = t;
      issue_rob_tag[l]  = r;
   endtask

   // Both lanes ADD tag+1000, rob = tag; one clock edge; inputs idle afterwards.
   task automatic issue_tags(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1,
                             input logic blk);
      issue_valid = v;
      set_lane(0, 8'h01, {58'd0, t0}, 64'd1000, t0, t0);
      set_lane(1, 8'h01, {58'd0, t1}, 64'd1000, t1, t1);
      cdb_block = blk;
      step();
      issue_valid = '0;
      cdb_block   = 1'b0;
   endtask

   task automatic chk_lane(input int j, input logic [5:0] t);
      chk($sformatf("cdb_tag[%0d]", j), 64'(cdb_tag[j]), 64'(t));
      chk($sformatf("cdb_value[%0d]", j), cdb_value[j], {58'd0, t} + 64'd1000);
      chk($sformatf("cdb_rob[%0d]", j), 64'(cdb_rob_tag[j]), 64'(t));
   endtask

   logic [5:0]  mq [$];
   logic [5:0]  exp_b [$];
   logic [19:0] pat;
   logic [5:0]  ntag;
   logic        blk;
   int          room, n;

   initial begin
      reset = 1'b1;
      issue_valid = '0; issue_op = '0; issue_dst_tag = '0; issue_src1_val = '0;
      issue_src2_val = '0; issue_rob_tag = '0; cdb_block = 1'b0;

      vecs[0] = '{2'b01, 8'h01, 8'h00, 64'd5, 64'd3, 64'd0, 64'd0, 6'd10, 6'd0, 6'd0, 6'd0,
                  2'b01, 6'd10, 6'd0, 64'd8, 64'd0, 6'd0, 6'd0};
      vecs[1] = '{2'b11, 8'h02, 8'h06, 64'd5, 64'd7, 64'd1, 64'd63, 6'd11, 6'd12, 6'd1, 6'd2,
                  2'b11, 6'd11, 6'd12, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 6'd1, 6'd2};
      vecs[2] = '{2'b11, 8'h03, 8'h04, 64'hF0F0, 64'hFF00, 64'hF0F0, 64'hFF00, 6'd13, 6'd14, 6'd3, 6'd4,
                  2'b11, 6'd13, 6'd14, 64'hF000, 64'hFFF0, 6'd3, 6'd4};
      vecs[3] = '{2'b11, 8'h05, 8'h07, 64'hFF, 64'h0F, 64'h8000_0000_0000_0000, 64'd63, 6'd15, 6'd16, 6'd5, 6'd6,
                  2'b11, 6'd15, 6'd16, 64'hF0, 64'd1, 6'd5, 6'd6};
      vecs[4] = '{2'b11, 8'h06, 8'h00, 64'd1, 64'd64, 64'h1234, 64'd5, 6'd17, 6'd18, 6'd7, 6'd8,
                  2'b11, 6'd17, 6'd18, 64'd1, 64'h1234, 6'd7, 6'd8};
      vecs[5] = '{2'b11, 8'h01, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hDEAD, 64'd1, 6'd19, 6'd20, 6'd9, 6'd10,
                  2'b11, 6'd19, 6'd20, 64'd1, 64'hDEAD, 6'd9, 6'd10};
      vecs[6] = '{2'b10, 8'h00, 8'h01, 64'd0, 64'd0, 64'd1, 64'd1, 6'd0, 6'd21, 6'd0, 6'd11,
                  2'b01, 6'd21, 6'd0, 64'd2, 64'd0, 6'd11, 6'd0};
      vecs[7] = '{2'b00, 8'h01, 8'h01, 64'd9, 64'd9, 64'd9, 64'd9, 6'd1, 6'd2, 6'd1, 6'd2,
                  2'b00, 6'd0, 6'd0, 64'd0, 64'd0, 6'd0, 6'd0};
      vecs[8] = '{2'b11, 8'h07, 8'h02, 64'hF0, 64'h44, 64'd0, 64'd1, 6'd22, 6'd23, 6'd12, 6'd13,
                  2'b11, 6'd22, 6'd23, 64'hF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd12, 6'd13};

      step();
      step();
      chk("rst cdb_valid", 64'(cdb_valid), 64'd0);
      chk("rst cdb_tag", 64'(cdb_tag), 64'd0);
      chk("rst rq_count", 64'(rq_count), 64'd0);
      chk("rst exec_ready", 64'(exec_ready), 64'd1);
      chk("rst overflow", 64'(overflow_err), 64'd0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         issue_valid = vecs[i].v;
         set_lane(0, vecs[i].op0, vecs[i].a0, vecs[i].b0, vecs[i].t0, vecs[i].r0);
         set_lane(1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].t1, vecs[i].r1);
         cdb_block = 1'b0;
         step();
         issue_valid = '0;
         chk($sformatf("vec%0d valid", i), 64'(cdb_valid), 64'(vecs[i].ev));
         chk($sformatf("vec%0d rq_count", i), 64'(rq_count), 64'd0);
         if (vecs[i].ev[0]) begin
            chk($sformatf("vec%0d tag0", i), 64'(cdb_tag[0]), 64'(vecs[i].et0));
            chk($sformatf("vec%0d val0", i), cdb_value[0], vecs[i].ex0);
            chk($sformatf("vec%0d rob0", i), 64'(cdb_rob_tag[0]), 64'(vecs[i].er0));
         end
         if (vecs[i].ev[1]) begin
            chk($sformatf("vec%0d tag1", i), 64'(cdb_tag[1]), 64'(vecs[i].et1));
            chk($sformatf("vec%0d val1", i), cdb_value[1], vecs[i].ex1);
            chk($sformatf("vec%0d rob1", i), 64'(cdb_rob_tag[1]), 64'(vecs[i].er1));
         end
      end

      // Blocked for two cycles, then drain in issue order.
      issue_tags(2'b11, 6'd20, 6'd21, 1'b1);
      chk("blk1 valid", 64'(cdb_valid), 64'd0);
      chk("blk1 rq_count", 64'(rq_count), 64'd2);
      chk("blk1 exec_ready", 64'(exec_ready), 64'd1);
      issue_tags(2'b11, 6'd22, 6'd23, 1'b1);
      chk("blk2 valid", 64'(cdb_valid), 64'd0);
      chk("blk2 rq_count", 64'(rq_count), 64'd4);
      chk("blk2 exec_ready", 64'(exec_ready), 64'd0);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("drain1 valid", 64'(cdb_valid), 64'd3);
      chk_lane(0, 6'd20);
      chk_lane(1, 6'd21);
      chk("drain1 rq_count", 64'(rq_count), 64'd2);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("drain2 valid", 64'(cdb_valid), 64'd3);
      chk_lane(0, 6'd22);
      chk_lane(1, 6'd23);
      chk("drain2 rq_count", 64'(rq_count), 64'd0);

      // Head/tail wrap: block pattern with a reference ordering scoreboard.
      pat  = 20'b0011_0110_1011_1001_1011;
      ntag = 6'd40;
      for (int c = 0; c < 24; c++) begin
         blk  = (c < 20) ? pat[c] : 1'b0;
         room = 4 + (blk ? 0 : 2) - mq.size();
         n    = (c >= 20) ? 0 : ((room < 2) ? room : 2);
         for (int i = 0; i < n; i++) mq.push_back(6'(ntag + 6'(i)));
         exp_b.delete();
         if (!blk) while (exp_b.size() < 2 && mq.size() > 0) exp_b.push_back(mq.pop_front());
         issue_tags((n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00, ntag, 6'(ntag + 6'd1), blk);
         ntag = 6'(ntag + 6'(n));
         chk($sformatf("wrap%0d valid", c), 64'(cdb_valid),
             (exp_b.size() == 2) ? 64'd3 : (exp_b.size() == 1) ? 64'd1 : 64'd0);
         for (int j = 0; j < exp_b.size(); j++) chk_lane(j, exp_b[j]);
         chk($sformatf("wrap%0d rq_count", c), 64'(rq_count), 64'(mq.size()));
      end

      // Full queue plus blocked issue: both lanes dropped, queued results intact.
      chk("pre-ovf overflow", 64'(overflow_err), 64'd0);
      issue_tags(2'b11, 6'd30, 6'd31, 1'b1);
      issue_tags(2'b11, 6'd32, 6'd33, 1'b1);
      chk("full exec_ready", 64'(exec_ready), 64'd0);
      issue_tags(2'b11, 6'd34, 6'd35, 1'b1);
      chk("ovf overflow", 64'(overflow_err), 64'd1);
      chk("ovf rq_count", 64'(rq_count), 64'd4);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("ovf d1 valid", 64'(cdb_valid), 64'd3);
      chk_lane(0, 6'd30);
      chk_lane(1, 6'd31);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("ovf d2 valid", 64'(cdb_valid), 64'd3);
      chk_lane(0, 6'd32);
      chk_lane(1, 6'd33);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("ovf d3 valid", 64'(cdb_valid), 64'd0);
      chk("ovf sticky", 64'(overflow_err), 64'd1);

      // Asynchronous reset with three results queued.
      issue_tags(2'b11, 6'd40, 6'd41, 1'b1);
      issue_tags(2'b01, 6'd42, 6'd0, 1'b1);
      chk("pre-rst rq_count", 64'(rq_count), 64'd3);
      reset = 1'b1;
      #1;
      chk("async rst valid", 64'(cdb_valid), 64'd0);
      chk("async rst rq_count", 64'(rq_count), 64'd0);
      chk("async rst exec_ready", 64'(exec_ready), 64'd1);
      chk("async rst overflow", 64'(overflow_err), 64'd0);
      #3;
      reset = 1'b0;
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("post-rst valid", 64'(cdb_valid), 64'd0);
      chk("post-rst rq_count", 64'(rq_count), 64'd0);

      // Partial acceptance: lane0 fits, lane1 dropped; then full queue with CDB free.
      issue_tags(2'b11, 6'd50, 6'd51, 1'b1);
      issue_tags(2'b01, 6'd52, 6'd0, 1'b1);
      chk("part exec_ready", 64'(exec_ready), 64'd0);
      issue_tags(2'b11, 6'd54, 6'd55, 1'b1);
      chk("part rq_count", 64'(rq_count), 64'd4);
      chk("part overflow", 64'(overflow_err), 64'd1);
      issue_tags(2'b11, 6'd56, 6'd57, 1'b0);
      chk("fullflow valid", 64'(cdb_valid), 64'd3);
      chk_lane(0, 6'd50);
      chk_lane(1, 6'd51);
      chk("fullflow rq_count", 64'(rq_count), 64'd4);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk_lane(0, 6'd52);
      chk_lane(1, 6'd54);
      issue_tags(2'b00, 6'd0, 6'd0, 1'b0);
      chk("final valid", 64'(cdb_valid), 64'd3);
      chk_lane(0, 6'd56);
      chk_lane(1, 6'd57);
      chk("final rq_count", 64'(rq_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
